fetch_linebuf: RTL and testbench

Instruction prefetch line buffer between the instruction SRAM and the fetch stage. It issues sequential 64-bit line reads to the isram, tags each returned line with its address, and queues lines in a small FIFO for fetch to consume. It yields the SRAM port to load/store accesses and flushes on any redirect (branch mispredict, trap, mret). This gives fetch a stall-tolerant line source in place of ad-hoc hold registers.

---
 rtl/fetch_linebuf_if.sv | 30 +++
 rtl/fetch_linebuf.sv | 130 +++++++++++++
 tb/tb_fetch_linebuf.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_linebuf_if.sv
// Fetch line buffer bus: isram request/response, redirect/steal control and fetch-side line port.
// The slave modport is the buffer itself; the master modport is the surrounding core/SRAM side.
interface fetch_linebuf_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   boot_addr;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          lr_isram_cs;
  logic          isram_cs;
  logic [28:0]   isram_adr;
  logic [63:0]   instr_fromsram;
  logic          line_valid;
  logic [28:0]   line_adr;
  logic [63:0]   line_data;
  logic          line_pop;
  logic [CW-1:0] buf_count;

  modport slave (
    input  boot_addr, redirect, redirect_pc, lr_isram_cs, instr_fromsram, line_pop,
    output isram_cs, isram_adr, line_valid, line_adr, line_data, buf_count
  );

  modport master (
    output boot_addr, redirect, redirect_pc, lr_isram_cs, instr_fromsram, line_pop,
    input  isram_cs, isram_adr, line_valid, line_adr, line_data, buf_count
  );
endinterface

// File: rtl/fetch_linebuf.sv
// Instruction prefetch line buffer: sequential 64-bit isram line reads queued in a small FIFO.
// Optional same-cycle bypass of an arriving line into an empty FIFO under `FETCH_BYPASS_EN.
module fetch_linebuf #(
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            cpurst,
  fetch_linebuf_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthC = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e        state_q, state_d;
  logic [28:0]   next_adr_q, next_adr_d;
  logic          inflight_q, inflight_d;
  logic [28:0]   inflight_adr_q, inflight_adr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [28:0]   fifo_adr_q [DEPTH];
  logic [28:0]   fifo_adr_d [DEPTH];
  logic [63:0]   fifo_data_q [DEPTH];
  logic [63:0]   fifo_data_d [DEPTH];

  logic          issue;
  logic          resp_ok;
  logic          write_en;
  logic          pop_reg;
  logic          fifo_nonempty;
  logic [CW:0]   credit;
`ifdef FETCH_BYPASS_EN
  logic          bypass;
`endif

  // Low address bits select a word within the line and are not needed here.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.boot_addr[2:0], bus.redirect_pc[2:0]};

  always_comb begin
    fifo_nonempty = (count_q != '0);
    // A redirect in the response cycle kills the line still in flight.
    resp_ok       = inflight_q & ~bus.redirect;
    credit        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue         = (state_q == StRun) & ~bus.lr_isram_cs & ~bus.redirect & (credit < DepthC);
    pop_reg       = bus.line_pop & fifo_nonempty;

    bus.isram_cs  = issue;
    bus.isram_adr = next_adr_q;
    bus.buf_count = count_q;

`ifdef FETCH_BYPASS_EN
    bypass         = resp_ok & ~fifo_nonempty;
    write_en       = resp_ok & ~(bypass & bus.line_pop);
    bus.line_valid = fifo_nonempty | bypass;
    bus.line_adr   = bypass ? inflight_adr_q     : fifo_adr_q[rptr_q];
    bus.line_data  = bypass ? bus.instr_fromsram : fifo_data_q[rptr_q];
`else
    write_en       = resp_ok;
    bus.line_valid = fifo_nonempty;
    bus.line_adr   = fifo_adr_q[rptr_q];
    bus.line_data  = fifo_data_q[rptr_q];
`endif
  end

  always_comb begin
    state_d        = StRun;
    next_adr_d     = next_adr_q;
    inflight_d     = issue;
    inflight_adr_d = issue ? next_adr_q : inflight_adr_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    count_d        = count_q;
    fifo_adr_d     = fifo_adr_q;
    fifo_data_d    = fifo_data_q;

    if (state_q == StBoot) begin
      next_adr_d = bus.boot_addr[31:3];
    end
    if (bus.redirect) begin
      next_adr_d = bus.redirect_pc[31:3];
    end else if (issue) begin
      next_adr_d = next_adr_q + 29'd1;
    end

    if (bus.redirect) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (write_en) begin
        fifo_adr_d[wptr_q]  = inflight_adr_q;
        fifo_data_d[wptr_q] = bus.instr_fromsram;
        wptr_d              = wptr_q + PW'(1);
      end
      if (pop_reg) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(write_en) - CW'(pop_reg);
    end
  end

  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state_q        <= StBoot;
      next_adr_q     <= '0;
      inflight_q     <= 1'b0;
      inflight_adr_q <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_adr_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      next_adr_q     <= next_adr_d;
      inflight_q     <= inflight_d;
      inflight_adr_q <= inflight_adr_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      fifo_adr_q     <= fifo_adr_d;
      fifo_data_q    <= fifo_data_d;
    end
  end
endmodule

// File: tb/tb_fetch_linebuf.sv
// Directed bench for fetch_linebuf (default build, DEPTH=4) with a one-cycle-latency isram model.
module tb_fetch_linebuf;
  logic clk;
  logic cpurst;
  int   checks;
  int   failures;

  fetch_linebuf_if #(.DEPTH(4)) ifc ();

  fetch_linebuf #(.DEPTH(4)) dut (
    .clk    (clk),
    .cpurst (cpurst),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] line_of(input logic [28:0] a);
    return {3'b101, a, ~{3'b101, a}};
  endfunction

  // Synchronous SRAM: data for the address requested this cycle appears next cycle.
  always @(posedge clk) begin
    if (ifc.isram_cs) ifc.instr_fromsram <= line_of(ifc.isram_adr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] boot, input logic pop);
    ifc.boot_addr   = boot;
    ifc.line_pop    = pop;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;
    ifc.lr_isram_cs = 1'b0;
    cpurst          = 1'b1;
    @(posedge clk);
    #2;
    cpurst = 1'b0;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ifc.instr_fromsram = '0;
    ifc.boot_addr   = 32'h0000_1000;
    ifc.line_pop    = 1'b1;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;
    ifc.lr_isram_cs = 1'b0;
    cpurst          = 1'b1;
    #1;
    chk("rst_cs",    {63'd0, ifc.isram_cs},   64'd0);
    chk("rst_adr",   {35'd0, ifc.isram_adr},  64'd0);
    chk("rst_valid", {63'd0, ifc.line_valid}, 64'd0);
    chk("rst_ladr",  {35'd0, ifc.line_adr},   64'd0);
    chk("rst_ldata", ifc.line_data,           64'd0);
    chk("rst_count", {61'd0, ifc.buf_count},  64'd0);

    // Boot with pop held high.
    do_reset(32'h0000_1000, 1'b1);
    chk("boot_c0_cs", {63'd0, ifc.isram_cs}, 64'd0);
    cyc(); #1;
    chk("boot_c1_cs",  {63'd0, ifc.isram_cs},  64'd1);
    chk("boot_c1_adr", {35'd0, ifc.isram_adr}, 64'h200);
    cyc(); #1;
    chk("boot_c2_adr",   {35'd0, ifc.isram_adr},  64'h201);
    chk("boot_c2_valid", {63'd0, ifc.line_valid}, 64'd0);
    cyc(); #1;
    chk("boot_c3_valid", {63'd0, ifc.line_valid}, 64'd1);
    chk("boot_c3_ladr",  {35'd0, ifc.line_adr},   64'h200);
    chk("boot_c3_data",  ifc.line_data,           line_of(29'h200));
    chk("boot_c3_adr",   {35'd0, ifc.isram_adr},  64'h202);
    cyc(); #1;
    chk("boot_c4_ladr",  {35'd0, ifc.line_adr},   64'h201);
    chk("boot_c4_cnt",   {61'd0, ifc.buf_count},  64'd1);

    // Backpressure: no pops, exactly DEPTH requests.
    do_reset(32'h0000_1000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("bp_req_cs",  {63'd0, ifc.isram_cs},  64'd1);
      chk("bp_req_adr", {35'd0, ifc.isram_adr}, 64'h200 + 64'(i));
    end
    cyc(); #1;
    chk("bp_c5_cs", {63'd0, ifc.isram_cs}, 64'd0);
    cyc(); #1;
    chk("bp_c6_cs",  {63'd0, ifc.isram_cs},  64'd0);
    chk("bp_c6_cnt", {61'd0, ifc.buf_count}, 64'd4);
    cyc(); ifc.line_pop = 1'b1; #1;
    chk("bp_pop_cs", {63'd0, ifc.isram_cs}, 64'd0);
    cyc(); ifc.line_pop = 1'b0; #1;
    chk("bp_c8_cs",   {63'd0, ifc.isram_cs},  64'd1);
    chk("bp_c8_adr",  {35'd0, ifc.isram_adr}, 64'h204);
    chk("bp_c8_cnt",  {61'd0, ifc.buf_count}, 64'd3);
    chk("bp_c8_ladr", {35'd0, ifc.line_adr},  64'h201);

    // Redirect while 0x203 is in flight, then port steal, then address wrap.
    do_reset(32'h0000_1000, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    cyc(); ifc.redirect = 1'b1; ifc.redirect_pc = 32'h0000_2008; #1;
    chk("rd_cs", {63'd0, ifc.isram_cs}, 64'd0);
    cyc(); ifc.redirect = 1'b0; #1;
    chk("rd_cnt",   {61'd0, ifc.buf_count},  64'd0);
    chk("rd_valid", {63'd0, ifc.line_valid}, 64'd0);
    chk("rd_adr",   {35'd0, ifc.isram_adr},  64'h401);
    cyc(); #1;
    chk("rd_c7_valid", {63'd0, ifc.line_valid}, 64'd0);
    chk("rd_c7_adr",   {35'd0, ifc.isram_adr},  64'h402);
    cyc(); ifc.line_pop = 1'b1; #1;
    chk("rd_c8_ladr", {35'd0, ifc.line_adr},  64'h401);
    chk("rd_c8_adr",  {35'd0, ifc.isram_adr}, 64'h403);
    cyc(); ifc.lr_isram_cs = 1'b1; #1;
    chk("st_c9_cs",   {63'd0, ifc.isram_cs}, 64'd0);
    chk("st_c9_ladr", {35'd0, ifc.line_adr}, 64'h402);
    cyc(); #1;
    chk("st_c10_cs",   {63'd0, ifc.isram_cs}, 64'd0);
    chk("st_c10_ladr", {35'd0, ifc.line_adr}, 64'h403);
    chk("st_c10_data", ifc.line_data,         line_of(29'h403));
    cyc(); #1;
    chk("st_c11_cs",    {63'd0, ifc.isram_cs},   64'd0);
    chk("st_c11_valid", {63'd0, ifc.line_valid}, 64'd0);
    cyc(); ifc.lr_isram_cs = 1'b0; #1;
    chk("st_c12_cs",  {63'd0, ifc.isram_cs},  64'd1);
    chk("st_c12_adr", {35'd0, ifc.isram_adr}, 64'h404);
    cyc(); #1;
    chk("st_c13_adr", {35'd0, ifc.isram_adr}, 64'h405);
    cyc(); #1;
    chk("st_c14_ladr", {35'd0, ifc.line_adr}, 64'h404);
    cyc(); ifc.redirect = 1'b1; ifc.redirect_pc = 32'hFFFF_FFF8; #1;
    chk("wr_rd_cs", {63'd0, ifc.isram_cs}, 64'd0);
    cyc(); ifc.redirect = 1'b0; #1;
    chk("wr_adr0",  {35'd0, ifc.isram_adr},  64'h1FFF_FFFF);
    chk("wr_valid", {63'd0, ifc.line_valid}, 64'd0);
    cyc(); #1;
    chk("wr_adr1", {35'd0, ifc.isram_adr}, 64'h0);
    cyc(); #1;
    chk("wr_ladr0", {35'd0, ifc.line_adr}, 64'h1FFF_FFFF);
    chk("wr_data0", ifc.line_data,         line_of(29'h1FFF_FFFF));
    cyc(); #1;
    chk("wr_ladr1", {35'd0, ifc.line_adr}, 64'h0);

    // Async reset with three lines queued and 0x203 in flight.
    do_reset(32'h0000_1000, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("ar_pre_cnt", {61'd0, ifc.buf_count}, 64'd3);
    ifc.boot_addr = 32'h0000_3000;
    cpurst = 1'b1;
    #1;
    chk("ar_cs",    {63'd0, ifc.isram_cs},   64'd0);
    chk("ar_adr",   {35'd0, ifc.isram_adr},  64'd0);
    chk("ar_valid", {63'd0, ifc.line_valid}, 64'd0);
    chk("ar_ladr",  {35'd0, ifc.line_adr},   64'd0);
    chk("ar_ldata", ifc.line_data,           64'd0);
    chk("ar_cnt",   {61'd0, ifc.buf_count},  64'd0);
    @(posedge clk);
    #2;
    cpurst = 1'b0;
    #1;
    chk("ar_c0_cnt",   {61'd0, ifc.buf_count},  64'd0);
    chk("ar_c0_valid", {63'd0, ifc.line_valid}, 64'd0);
    cyc(); #1;
    chk("ar_c1_adr", {35'd0, ifc.isram_adr}, 64'h600);
    cyc(); #1;
    chk("ar_c2_cnt", {61'd0, ifc.buf_count}, 64'd0);
    cyc(); #1;
    chk("ar_c3_ladr", {35'd0, ifc.line_adr},  64'h600);
    chk("ar_c3_cnt",  {61'd0, ifc.buf_count}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
